// File: rtl/decoder_stage_controller_master_pkg.sv
// Shared stage encodings, command codes and link-width helpers for the
// stage-controller master and its leaf link.
package decoder_stage_controller_master_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                = 3'd0,
        STAGE_SPREAD_CLUSTER      = 3'd1,
        STAGE_GROW_BOUNDARY       = 3'd2,
        STAGE_SYNC_IS_ODD_CLUSTER = 3'd3,
        STAGE_MEASUREMENT_LOADING = 3'd4,
        STAGE_RESULT_CALCULATING  = 3'd5
    } stage_t;

    localparam logic [2:0] CMD_ADV  = 3'd1;
    localparam logic [2:0] CMD_FIN  = 3'd2;
    localparam logic [2:0] CMD_ABT  = 3'd3;
    localparam logic [2:0] CMD_TERM = 3'd4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int address_width(input int dx, input int dz);
        return $clog2(max2(dx, dz) + 1);
    endfunction

    function automatic int master_fifo_width(input int dx, input int dz);
        return 2 * address_width(dx, dz) + 2;
    endfunction

    function automatic int deadlock_default(input int dx, input int dz);
        return dx * dz * max2(dx, dz) * 10;
    endfunction

endpackage

// File: rtl/decoder_stage_controller_master_sc_command_sender.sv
// One-entry valid/ready holding register for the outgoing command link.
// A loaded word stays put until the receiver accepts it.
module sc_command_sender #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (out_valid) begin
            if (out_ready) out_valid <= 1'b0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
        end
    end

endmodule

// File: rtl/decoder_stage_controller_master.sv
// Initiator of the stage-controller protocol: sequences one decoding round on a
// leaf through ADV/FIN/ABT commands and collects the optional result stream.
module decoder_stage_controller_master
    import decoder_stage_controller_master_pkg::*;
#(
    parameter int CODE_DISTANCE_X           = 5,
    parameter int CODE_DISTANCE_Z           = 5,
    parameter int ITERATION_COUNTER_WIDTH   = 8,
    parameter int BOUNDARY_GROW_DELAY       = 3,
    parameter int SPREAD_CLUSTER_DELAY      = 2,
    parameter int SYNC_IS_ODD_CLUSTER_DELAY = 2,
    parameter int LINK_LATENCY              = 4,
    parameter int EXPECT_RESULT_STREAM      = 0,
    parameter int DEADLOCK_THRESHOLD        = deadlock_default(CODE_DISTANCE_X, CODE_DISTANCE_Z),
    localparam int MFW = master_fifo_width(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_round_start,
    input  logic                               abort,
    input  logic                               has_message_flying_otherside,
    input  logic                               has_odd_clusters_otherside,
    output logic [MFW-1:0]                     sc_fifo_out_data,
    output logic                               sc_fifo_out_valid,
    input  logic                               sc_fifo_out_ready,
    input  logic [MFW-1:0]                     sc_fifo_in_data,
    input  logic                               sc_fifo_in_valid,
    output logic                               sc_fifo_in_ready,
    output logic [STAGE_WIDTH-1:0]             stage,
    output logic                               busy,
    output logic                               result_valid,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic [31:0]                        cycle_counter,
    output logic                               deadlock,
    output logic [MFW-1:0]                     result_word,
    output logic                               result_word_valid,
    output logic                               protocol_error
);

    localparam logic [31:0]    SPREAD_MIN = 32'(SPREAD_CLUSTER_DELAY + LINK_LATENCY);
    localparam logic [31:0]    SYNC_MIN   = 32'(SYNC_IS_ODD_CLUSTER_DELAY + LINK_LATENCY);
    localparam logic [31:0]    GROW_MIN   = 32'(BOUNDARY_GROW_DELAY + LINK_LATENCY);
    localparam logic [31:0]    THRESHOLD  = 32'(DEADLOCK_THRESHOLD);
    localparam logic [MFW-1:0] TERM_WORD  = MFW'(CMD_TERM);

    stage_t      stage_q, stage_n, target_q, push_target;
    logic        push;
    logic [2:0]  push_code;
    logic        commit, timeout, abort_req, is_term, round_done, forward_word;
    logic        abort_q;
    logic [31:0] cycles_in_stage;

    sc_command_sender #(.WIDTH(MFW)) u_sender (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (MFW'(push_code)),
        .out_data  (sc_fifo_out_data),
        .out_valid (sc_fifo_out_valid),
        .out_ready (sc_fifo_out_ready)
    );

    assign commit       = sc_fifo_out_valid && sc_fifo_out_ready;
    assign timeout      = (stage_q != STAGE_IDLE) && (cycles_in_stage > THRESHOLD);
    // A latched abort survives the GROW->SPREAD hop so the round still ends with FIN.
    assign abort_req    = (stage_q != STAGE_IDLE) && (abort || abort_q || timeout);
    assign is_term      = sc_fifo_in_valid && (sc_fifo_in_data == TERM_WORD);
    assign forward_word = (EXPECT_RESULT_STREAM != 0) && (stage_q == STAGE_RESULT_CALCULATING)
                          && sc_fifo_in_valid && !is_term;

    assign stage            = stage_q;
    assign busy             = (stage_q != STAGE_IDLE);
    assign sc_fifo_in_ready = !reset;

    always_comb begin
        push        = 1'b0;
        push_code   = CMD_ADV;
        push_target = stage_q;
        stage_n     = stage_q;
        round_done  = 1'b0;
        case (stage_q)
            STAGE_IDLE: begin
                if (new_round_start && !sc_fifo_out_valid) begin
                    push        = 1'b1;
                    push_target = STAGE_SPREAD_CLUSTER;
                end
            end
            STAGE_SPREAD_CLUSTER: begin
                if (!sc_fifo_out_valid) begin
                    if (abort_req) begin
                        push        = 1'b1;
                        push_code   = CMD_FIN;
                        push_target = STAGE_IDLE;
                    end else if (cycles_in_stage >= SPREAD_MIN && !has_message_flying_otherside) begin
                        push        = 1'b1;
                        push_target = STAGE_SYNC_IS_ODD_CLUSTER;
                    end
                end
            end
            STAGE_SYNC_IS_ODD_CLUSTER: begin
                if (!sc_fifo_out_valid) begin
                    if (abort_req) begin
                        push        = 1'b1;
                        push_code   = CMD_ABT;
                        push_target = STAGE_IDLE;
                    end else if (cycles_in_stage >= SYNC_MIN && !has_message_flying_otherside) begin
                        push = 1'b1;
                        if (has_odd_clusters_otherside) begin
                            push_target = STAGE_GROW_BOUNDARY;
                        end else begin
                            push_code   = CMD_FIN;
                            push_target = STAGE_RESULT_CALCULATING;
                        end
                    end
                end
            end
            STAGE_GROW_BOUNDARY: begin
                if (!sc_fifo_out_valid && cycles_in_stage >= GROW_MIN) begin
                    push        = 1'b1;
                    push_target = STAGE_SPREAD_CLUSTER;
                end
            end
            STAGE_RESULT_CALCULATING: begin
                if (EXPECT_RESULT_STREAM == 0) begin
                    stage_n    = STAGE_IDLE;
                    round_done = !abort_req;
                end else if (is_term) begin
                    stage_n    = STAGE_IDLE;
                    round_done = 1'b1;
                end else if (abort_req) begin
                    stage_n = STAGE_IDLE;
                end
            end
            default: stage_n = STAGE_IDLE;
        endcase
        if (commit) stage_n = target_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q           <= STAGE_IDLE;
            target_q          <= STAGE_IDLE;
            cycles_in_stage   <= '0;
            cycle_counter     <= '0;
            iteration_counter <= '0;
            abort_q           <= 1'b0;
            deadlock          <= 1'b0;
            result_valid      <= 1'b0;
            result_word       <= '0;
            result_word_valid <= 1'b0;
            protocol_error    <= 1'b0;
        end else begin
            stage_q <= stage_n;
            if (push) target_q <= push_target;

            if (stage_n != stage_q || stage_q == STAGE_IDLE) cycles_in_stage <= '0;
            else if (cycles_in_stage != '1) cycles_in_stage <= cycles_in_stage + 32'd1;

            if (commit && stage_q == STAGE_IDLE) begin
                cycle_counter     <= 32'd1;
                iteration_counter <= '0;
            end else begin
                if (stage_q != STAGE_IDLE && cycle_counter != '1)
                    cycle_counter <= cycle_counter + 32'd1;
                if (commit && target_q == STAGE_GROW_BOUNDARY)
                    iteration_counter <= iteration_counter + ITERATION_COUNTER_WIDTH'(1);
            end

            if (stage_n == STAGE_IDLE) abort_q <= 1'b0;
            else if (abort_req)        abort_q <= 1'b1;

            if (stage_q == STAGE_IDLE && new_round_start && !sc_fifo_out_valid) deadlock <= 1'b0;
            else if (timeout)                                                   deadlock <= 1'b1;

            result_valid      <= round_done;
            result_word_valid <= forward_word;
            if (forward_word) result_word <= sc_fifo_in_data;
            if (sc_fifo_in_valid && stage_q != STAGE_RESULT_CALCULATING) protocol_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decoder_stage_controller_master.sv
// Bench for decoder_stage_controller_master: a leaf-reaction model predicts every
// output each cycle; a vector table and directed sequences cover the corner cases.
module tb_decoder_stage_controller_master;

    localparam int MFW = 8;
    localparam int THR = 80;
    localparam int SP_MIN = 2 + 4;
    localparam int SY_MIN = 2 + 4;
    localparam int GR_MIN = 3 + 4;
    localparam int S_IDLE = 0, S_SPREAD = 1, S_GROW = 2, S_SYNC = 3, S_RESULT = 5;
    localparam int C_ADV = 1, C_FIN = 2, C_ABT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, new_round_start, abort, mf, odd, out_ready, in_valid, in_ready;
    logic [MFW-1:0] in_data, out_data, result_word;
    logic           out_valid, busy, result_valid, deadlock, result_word_valid, protocol_error;
    logic [2:0]     stage;
    logic [7:0]     iteration_counter;
    logic [31:0]    cycle_counter;

    decoder_stage_controller_master #(
        .CODE_DISTANCE_X(5),
        .CODE_DISTANCE_Z(5),
        .EXPECT_RESULT_STREAM(1),
        .DEADLOCK_THRESHOLD(THR)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .new_round_start              (new_round_start),
        .abort                        (abort),
        .has_message_flying_otherside (mf),
        .has_odd_clusters_otherside   (odd),
        .sc_fifo_out_data             (out_data),
        .sc_fifo_out_valid            (out_valid),
        .sc_fifo_out_ready            (out_ready),
        .sc_fifo_in_data              (in_data),
        .sc_fifo_in_valid             (in_valid),
        .sc_fifo_in_ready             (in_ready),
        .stage                        (stage),
        .busy                         (busy),
        .result_valid                 (result_valid),
        .iteration_counter            (iteration_counter),
        .cycle_counter                (cycle_counter),
        .deadlock                     (deadlock),
        .result_word                  (result_word),
        .result_word_valid            (result_word_valid),
        .protocol_error               (protocol_error)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Leaf reaction to a command: where the leaf's stage goes next.
    function automatic int leaf_next(input int s, input int code);
        if (code == C_ABT) return S_IDLE;
        if (code == C_FIN) return (s == S_SYNC) ? S_RESULT : S_IDLE;
        case (s)
            S_IDLE:   return S_SPREAD;
            S_SPREAD: return S_SYNC;
            S_SYNC:   return S_GROW;
            default:  return S_SPREAD;
        endcase
    endfunction

    int          m_stage, m_dwell, m_code;
    bit          m_pend, m_abl, m_dead, m_perr, m_rv, m_rwv;
    logic [7:0]  m_iter, m_rw;
    logic [31:0] m_cyc;

    task automatic model_step();
        bit act, tmo, abq, commit, term, issue;
        int code, nstage;
        if (reset) begin
            m_stage = S_IDLE; m_dwell = 0; m_code = 0; m_pend = 0; m_abl = 0; m_dead = 0;
            m_perr = 0; m_rv = 0; m_rwv = 0; m_iter = 0; m_rw = 0; m_cyc = 0;
            return;
        end
        act    = (m_stage != S_IDLE);
        tmo    = act && (m_dwell > THR);
        abq    = act && (abort || m_abl || tmo);
        commit = m_pend && out_ready;
        term   = in_valid && (in_data == 8'd4);
        issue  = 0;
        code   = C_ADV;
        if (!m_pend) begin
            case (m_stage)
                S_IDLE:   issue = new_round_start;
                S_SPREAD: begin
                    if (abq) begin issue = 1; code = C_FIN; end
                    else issue = (m_dwell >= SP_MIN) && !mf;
                end
                S_SYNC: begin
                    if (abq) begin issue = 1; code = C_ABT; end
                    else if (m_dwell >= SY_MIN && !mf) begin issue = 1; code = odd ? C_ADV : C_FIN; end
                end
                S_GROW:   issue = (m_dwell >= GR_MIN);
                default:  issue = 0;
            endcase
        end
        nstage = m_stage;
        m_rv = 0;
        if (commit) nstage = leaf_next(m_stage, m_code);
        else if (m_stage == S_RESULT) begin
            if (term) begin nstage = S_IDLE; m_rv = 1; end
            else if (abq) nstage = S_IDLE;
        end
        m_rwv = (m_stage == S_RESULT) && in_valid && !term;
        if (m_rwv) m_rw = in_data;
        if (in_valid && m_stage != S_RESULT) m_perr = 1;
        if (m_stage == S_IDLE && new_round_start && !m_pend) m_dead = 0;
        else if (tmo) m_dead = 1;
        if (commit && m_stage == S_IDLE) begin
            m_cyc = 1; m_iter = 0;
        end else begin
            if (act && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (commit && nstage == S_GROW) m_iter = m_iter + 1;
        end
        m_abl   = (nstage == S_IDLE) ? 0 : (abq ? 1 : m_abl);
        m_dwell = (nstage != m_stage) ? 0 : (act ? m_dwell + 1 : 0);
        if (commit) m_pend = 0;
        if (issue) begin m_pend = 1; m_code = code; end
        m_stage = nstage;
    endtask

    task automatic model_check();
        chk("stage", stage, m_stage);
        chk("busy", busy, m_stage != S_IDLE);
        chk("out_valid", out_valid, m_pend);
        if (m_pend) chk("out_data", out_data, m_code);
        chk("result_valid", result_valid, m_rv);
        chk("iteration_counter", iteration_counter, m_iter);
        chk("cycle_counter", cycle_counter, m_cyc);
        chk("deadlock", deadlock, m_dead);
        chk("result_word_valid", result_word_valid, m_rwv);
        if (m_rwv) chk("result_word", result_word, m_rw);
        chk("protocol_error", protocol_error, m_perr);
        chk("in_ready", in_ready, !reset);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        reset = 1; new_round_start = 0; abort = 0; mf = 0; odd = 0;
        out_ready = 1; in_valid = 0; in_data = '0;
        tick();
        reset = 0;
    endtask

    task automatic run_until_stage(input int s, input int budget, input string nm);
        int n = 0;
        while (stage !== 3'(s) && n < budget) begin
            tick();
            n++;
        end
        chk(nm, stage, s);
    endtask

    typedef struct {
        bit rst, nrs, ab, rdy;
        int e_stage, e_data, e_cyc;
        bit e_valid;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input bit rst, input bit nrs, input bit ab, input bit rdy,
                                input int st, input bit v, input int d, input int cyc);
        vec_t r;
        r.rst = rst; r.nrs = nrs; r.ab = ab; r.rdy = rdy;
        r.e_stage = st; r.e_valid = v; r.e_data = d; r.e_cyc = cyc;
        return r;
    endfunction

    int exp_cmds[$];
    int got_cmds[$];

    initial begin
        int grows, prev, n;
        bit saw;
        logic [7:0] words[3];

        vecs[0]  = mk(1, 0, 0, 1, S_IDLE,   0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 1, S_IDLE,   0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, S_IDLE,   1, C_ADV, 0);
        vecs[3]  = mk(0, 0, 0, 0, S_IDLE,   1, C_ADV, 0);
        vecs[4]  = mk(0, 0, 1, 0, S_IDLE,   1, C_ADV, 0);
        vecs[5]  = mk(0, 0, 0, 1, S_SPREAD, 0, 0, 1);
        for (int i = 6; i < 12; i++) vecs[i] = mk(0, 0, 0, 1, S_SPREAD, 0, 0, i - 4);
        vecs[12] = mk(0, 0, 0, 1, S_SPREAD, 1, C_ADV, 8);
        vecs[13] = mk(0, 0, 0, 1, S_SYNC,   0, 0, 9);

        reset = 1; new_round_start = 0; abort = 0; mf = 0; odd = 0;
        out_ready = 1; in_valid = 0; in_data = '0;
        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst; new_round_start = vecs[i].nrs;
            abort = vecs[i].ab;  out_ready = vecs[i].rdy;
            tick();
            chk("vec_stage", stage, vecs[i].e_stage);
            chk("vec_valid", out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid || vecs[i].rst) chk("vec_data", out_data, vecs[i].e_data);
            chk("vec_cycle_counter", cycle_counter, vecs[i].e_cyc);
        end

        // Loopback round: odd clusters for the first two SYNC visits.
        do_reset();
        exp_cmds.push_back(C_ADV);
        repeat (2) repeat (3) exp_cmds.push_back(C_ADV);
        exp_cmds.push_back(C_ADV);
        exp_cmds.push_back(C_FIN);
        new_round_start = 1;
        saw = 0;
        for (int c = 0; c < 400 && !saw; c++) begin
            odd = (m_iter < 2);
            in_valid = (m_stage == S_RESULT);
            in_data = 8'd4;
            if (out_valid && out_ready) got_cmds.push_back(int'(out_data));
            tick();
            new_round_start = 0;
            if (result_valid) saw = 1;
        end
        in_valid = 0;
        chk("loop_result_valid", saw, 1);
        chk("loop_iterations", iteration_counter, 2);
        chk("loop_cmd_count", got_cmds.size(), exp_cmds.size());
        for (int i = 0; i < exp_cmds.size() && i < got_cmds.size(); i++)
            chk("loop_cmd", got_cmds[i], exp_cmds[i]);

        // Back-pressure on the first ADV, then flying held in SPREAD.
        do_reset();
        out_ready = 0; new_round_start = 1;
        tick();
        new_round_start = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, C_ADV);
            chk("stall_stage", stage, S_IDLE);
        end
        out_ready = 1;
        tick();
        chk("stall_commit_stage", stage, S_SPREAD);
        mf = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("flying_no_cmd", out_valid, 0);
        end
        mf = 0;
        tick();
        chk("flying_release_valid", out_valid, 1);
        chk("flying_release_data", out_data, C_ADV);

        // SPREAD never settles: deadlock, FIN, back to IDLE.
        do_reset();
        mf = 1; new_round_start = 1;
        tick();
        new_round_start = 0;
        got_cmds.delete();
        n = 0;
        while (!(deadlock && stage == 3'(S_IDLE)) && n < 300) begin
            if (out_valid && out_ready) got_cmds.push_back(int'(out_data));
            tick();
            n++;
        end
        chk("deadlock_set", deadlock, 1);
        chk("deadlock_stage", stage, S_IDLE);
        chk("deadlock_last_cmd", got_cmds.size() > 0 ? got_cmds[$] : 0, C_FIN);
        mf = 0; new_round_start = 1;
        tick();
        new_round_start = 0;
        chk("deadlock_cleared", deadlock, 0);

        // Result stream: three words then the terminator.
        do_reset();
        new_round_start = 1;
        tick();
        new_round_start = 0;
        run_until_stage(S_RESULT, 100, "reach_result");
        words[0] = 8'h15; words[1] = 8'hA4; words[2] = 8'h0C;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = words[i];
            tick();
            chk("stream_word_valid", result_word_valid, 1);
            chk("stream_word", result_word, words[i]);
        end
        in_data = 8'd4;
        tick();
        in_valid = 0;
        chk("stream_result_valid", result_valid, 1);
        chk("stream_word_not_fwd", result_word_valid, 0);
        chk("stream_protocol_error", protocol_error, 0);

        // Terminator and abort in the same cycle: terminator wins.
        new_round_start = 1;
        tick();
        new_round_start = 0;
        run_until_stage(S_RESULT, 100, "reach_result2");
        abort = 1; in_valid = 1; in_data = 8'd4;
        tick();
        abort = 0; in_valid = 0;
        chk("term_vs_abort", result_valid, 1);

        // Stray word during GROW.
        odd = 1; new_round_start = 1;
        tick();
        new_round_start = 0;
        run_until_stage(S_GROW, 100, "reach_grow");
        in_valid = 1; in_data = 8'h33;
        tick();
        in_valid = 0;
        chk("grow_protocol_error", protocol_error, 1);

        // Reset during SYNC with ADV pending.
        do_reset();
        odd = 1; new_round_start = 1;
        tick();
        new_round_start = 0;
        n = 0;
        while (!(stage == 3'(S_SYNC) && iteration_counter == 8'd1) && n < 200) begin
            tick();
            n++;
        end
        chk("reach_sync2", stage, S_SYNC);
        out_ready = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("sync_adv_pending", out_valid, 1);
        reset = 1;
        tick();
        reset = 0; out_ready = 1;
        chk("rst_stage", stage, S_IDLE);
        chk("rst_valid", out_valid, 0);
        chk("rst_iter", iteration_counter, 0);
        chk("rst_cycles", cycle_counter, 0);

        // Iteration counter wraps after 256 grow phases.
        odd = 1; new_round_start = 1;
        tick();
        new_round_start = 0;
        grows = 0; n = 0;
        while (grows < 257 && n < 9000) begin
            prev = int'(stage);
            tick();
            if (stage == 3'(S_GROW) && prev != S_GROW) grows++;
            n++;
        end
        chk("wrap_grows", grows, 257);
        chk("wrap_iter", iteration_counter, 1);
        abort = 1;
        run_until_stage(S_IDLE, 100, "wrap_abort_idle");
        abort = 0;
        chk("abort_no_result", result_valid, 0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            reset = ($urandom_range(0, 699) == 0);
            new_round_start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 59) == 0);
            mf = ($urandom_range(0, 2) == 0);
            odd = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if (m_stage == S_RESULT) begin
                in_valid = $urandom_range(0, 1);
                in_data = ($urandom_range(0, 2) == 0) ? 8'd4 : 8'($urandom);
            end else begin
                in_valid = ($urandom_range(0, 299) == 0);
                in_data = 8'($urandom);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
